// File: rtl/demux_sel_sequencer_if.sv
// Request channel into the demux select sequencer.
// The producer offers a 2-bit destination channel and the sequencer answers with ready.
interface demux_sel_sequencer_if;
    logic       in_valid;
    logic [1:0] in_sel;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_sel,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_sel,
        output in_ready
    );
endinterface

// File: rtl/demux_sel_sequencer.sv
// Buffers destination-channel requests in a small FIFO and replays each one as a
// fixed-width enable strobe with a stable select and a guaranteed low gap afterwards.
module demux_sel_sequencer #(
    parameter int DEPTH   = 4,
    parameter int PULSE_W = 2,
    parameter int GAP     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    demux_sel_sequencer_if.slave       req,
    output logic [1:0]                 S,
    output logic                       E,
    output logic                       done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [3:0]  PULSE_LOAD = 4'(PULSE_W - 1);
    localparam logic [3:0]  GAP_LOAD   = 4'(GAP - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STROBE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    logic [1:0]    r_mem [0:DEPTH-1];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic [3:0]    r_timer;
    logic [1:0]    r_S;
    logic          r_E;
    logic          r_done;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_startStrobe;
    logic [1:0]    w_head;

    // Ready comes only from registered occupancy, so a pop never opens room in the same cycle.
    assign w_full        = (r_count == FULL_COUNT);
    assign w_empty       = (r_count == '0);
    assign w_push        = req.in_valid && !w_full;
    assign w_head        = r_mem[r_rdPtr];
    assign w_startStrobe = !w_empty &&
                           ((r_state == ST_IDLE) ||
                            ((r_state == ST_GAP) && (r_timer == 4'd0)));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= req.in_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_startStrobe) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_startStrobe})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // S is loaded only on the edge where E rises, so it never moves under a high enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_timer <= 4'd0;
            r_S     <= 2'd0;
            r_E     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_startStrobe) begin
                        r_S     <= w_head;
                        r_E     <= 1'b1;
                        r_timer <= PULSE_LOAD;
                        r_state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (r_timer == 4'd0) begin
                        r_E     <= 1'b0;
                        r_done  <= 1'b1;
                        r_timer <= GAP_LOAD;
                        r_state <= ST_GAP;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_timer == 4'd0) begin
                        if (w_startStrobe) begin
                            r_S     <= w_head;
                            r_E     <= 1'b1;
                            r_timer <= PULSE_LOAD;
                            r_state <= ST_STROBE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                default: begin
                    r_E     <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req.in_ready = !w_full;
    assign S            = r_S;
    assign E            = r_E;
    assign done         = r_done;
    assign count        = r_count;
    assign busy         = !w_empty || (r_state != ST_IDLE);

endmodule
